// File: rtl/stream_fifo.sv
// stream_fifo
// Parametrised synchronous FIFO built on a circular buffer with separate read
// and write pointers and an explicit occupancy register. Valid/ready handshakes
// on both sides, first-word fall-through read data, almost-full/almost-empty
// flags derived from the occupancy register, and a synchronous flush.
//
// Build option: define STREAM_FIFO_BYPASS_EN to forward a word straight from
// the input to the output when the FIFO is empty and the consumer is ready
// (zero latency, word never stored). Without the macro there is no
// combinational path from in_* to out_*, and the minimum latency is one cycle.

// Protocol checker bound inside stream_fifo; never contributes to logic.
module stream_fifo_chk #(
  parameter int DEPTH = 8
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic                     flush,
  input logic                     push,
  input logic                     pop,
  input logic                     full,
  input logic                     empty,
  input logic [$clog2(DEPTH):0]   count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_ZERO  = {CW{1'b0}};

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= C_DEPTH);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && empty));

  a_flush_empties: assert property (@(posedge clk) disable iff (!rst_n)
    flush |=> (count == C_ZERO));

endmodule

module stream_fifo #(
  parameter int DEPTH         = 8,
  parameter int BITS          = 64,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [BITS-1:0]        in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [BITS-1:0]        out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_AFULL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] C_AEMPTY = CW'(AEMPTY_THRESH);
  localparam logic [CW-1:0] C_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] C_ONE    = CW'(1);
  localparam logic [PW-1:0] P_ZERO   = {PW{1'b0}};
  localparam logic [PW-1:0] P_ONE    = PW'(1);

  // Storage and state
  logic [BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  // Combinational status and handshake
  logic            w_full;
  logic            w_empty;
  logic            w_bypass;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic [BITS-1:0] w_out_data;

  // Next-state values
  logic [PW-1:0]   w_wr_ptr_nxt;
  logic [PW-1:0]   w_rd_ptr_nxt;
  logic [CW-1:0]   w_count_nxt;

  // Occupancy decode from the count register only.
  always_comb begin
    w_full  = (r_count == C_DEPTH);
    w_empty = (r_count == C_ZERO);
  end

`ifdef STREAM_FIFO_BYPASS_EN
  // Empty FIFO with both sides ready: the word goes straight through.
  assign w_bypass = w_empty & in_valid & out_ready & ~flush;
`else
  assign w_bypass = 1'b0;
`endif

  // Handshake qualification. in_ready ignores out_ready on purpose: a full
  // FIFO refuses a word even when the head is popped in the same cycle.
  always_comb begin
    w_in_ready  = ~w_full & ~flush;
    w_out_valid = (~w_empty | w_bypass) & ~flush;
    w_push      = in_valid & w_in_ready & ~w_bypass;
    w_pop       = w_out_valid & out_ready & ~w_bypass;
  end

  // Head data select: forwarded input word during bypass, else stored head.
  always_comb begin
    if (w_bypass) begin
      w_out_data = in_data;
    end else begin
      w_out_data = r_mem[r_rd_ptr];
    end
  end

  // Pointer and occupancy next-state; flush empties the FIFO at the next edge.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    if (flush) begin
      w_wr_ptr_nxt = P_ZERO;
      w_rd_ptr_nxt = P_ZERO;
      w_count_nxt  = C_ZERO;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + P_ONE;
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + P_ONE;
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + C_ONE;
        2'b01:   w_count_nxt = r_count - C_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= P_ZERO;
      r_rd_ptr <= P_ZERO;
      r_count  <= C_ZERO;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage array: cleared by reset only; flush leaves contents in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {BITS{1'b0}};
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  assign in_ready     = w_in_ready;
  assign out_valid    = w_out_valid;
  assign out_data     = w_out_data;
  assign count        = r_count;
  assign almost_full  = (r_count >= C_AFULL);
  assign almost_empty = (r_count <= C_AEMPTY);

  stream_fifo_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (w_push),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .count (r_count)
  );

endmodule

// File: tb/tb_stream_fifo.sv
// Self-checking bench for stream_fifo: a reference occupancy model plus a
// scoreboard queue of words expected at the output, compared when popped.
module tb_stream_fifo;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;
  localparam int AFT   = 6;
  localparam int AET   = 1;

`ifdef STREAM_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic [BITS-1:0] in_data;
  logic            in_ready;
  logic            out_valid;
  logic [BITS-1:0] out_data;
  logic            out_ready;
  logic [3:0]      count;
  logic            almost_full;
  logic            almost_empty;

  int              n_vec = 0;
  int              n_err = 0;
  int              m_count = 0;
  logic [63:0]     sb [$];

  stream_fifo #(
    .DEPTH         (DEPTH),
    .BITS          (BITS),
    .AFULL_THRESH  (AFT),
    .AEMPTY_THRESH (AET)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Reset-state outputs; valid at any time while rst_n is low.
  task automatic check_reset(input string pfx);
    check_val({pfx, "_in_ready"}, 64'(in_ready), 64'h1);
    check_val({pfx, "_out_valid"}, 64'(out_valid), 64'h0);
    check_val({pfx, "_count"}, 64'(count), 64'h0);
    check_val({pfx, "_almost_full"}, 64'(almost_full), 64'h0);
    check_val({pfx, "_almost_empty"}, 64'(almost_empty), 64'h1);
    check_val({pfx, "_out_data"}, out_data, 64'h0);
  endtask

  // One clock cycle: drive, check against the model at the negedge, advance.
  task automatic step(input logic iv, input logic [63:0] id, input logic ordy, input logic fl);
    logic e_byp;
    logic e_ir;
    logic e_ov;
    logic e_push;
    logic e_pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
    e_byp  = BYP && (m_count == 0) && iv && ordy && !fl;
    e_ir   = (m_count != DEPTH) && !fl;
    e_ov   = ((m_count != 0) || e_byp) && !fl;
    e_push = iv && e_ir && !e_byp;
    e_pop  = e_ov && ordy && !e_byp;
    check_val("in_ready", 64'(in_ready), 64'(e_ir));
    check_val("out_valid", 64'(out_valid), 64'(e_ov));
    check_val("count", 64'(count), 64'(m_count));
    check_val("almost_full", 64'(almost_full), 64'(m_count >= AFT));
    check_val("almost_empty", 64'(almost_empty), 64'(m_count <= AET));
    if (e_byp) begin
      check_val("bypass_data", out_data, id);
    end else if (e_pop) begin
      check_val("out_data", out_data, sb[0]);
    end
    @(posedge clk);
    #1;
    if (fl) begin
      m_count = 0;
      sb.delete();
    end else begin
      if (e_push) begin
        sb.push_back(id);
        m_count++;
      end
      if (e_pop) begin
        void'(sb.pop_front());
        m_count--;
      end
    end
  endtask

  task automatic release_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    in_data   = 64'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_count = 0;
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 64'h0;
    out_ready = 1'b0;
    #2;
    check_reset("rst0");
    release_reset();

    // Fill to full, try a 9th word, drain; three rounds to wrap the pointers.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b1, 64'(i), 1'b0, 1'b0);
      end
      check_val("fill_count", 64'(count), 64'h8);
      step(1'b1, 64'h9, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        step(1'b0, 64'h0, 1'b1, 1'b0);
      end
      step(1'b0, 64'h0, 1'b1, 1'b0);
      check_val("drain_count", 64'(count), 64'h0);
    end

    // Simultaneous push/pop at count 4.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 64'h10 + 64'(i), 1'b0, 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0);
    end
    check_val("simul_count", 64'(count), 64'h4);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 64'h0, 1'b1, 1'b0);
    end

    // Full plus pop: push refused, count drops to 7.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 64'h20 + 64'(i), 1'b0, 1'b0);
    end
    step(1'b1, 64'h200, 1'b1, 1'b0);
    check_val("full_pop_count", 64'(count), 64'h7);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 64'h0, 1'b1, 1'b0);
    end

    // Flush at count 5, then 0xAA goes through; held flush keeps it empty.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 64'h30 + 64'(i), 1'b0, 1'b0);
    end
    step(1'b0, 64'h0, 1'b0, 1'b1);
    check_val("flush_count", 64'(count), 64'h0);
    step(1'b1, 64'hAA, 1'b0, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b1, 64'h40, 1'b0, 1'b0);
    step(1'b1, 64'h41, 1'b1, 1'b1);
    step(1'b1, 64'h42, 1'b1, 1'b1);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Empty FIFO with both sides ready: bypass or one-cycle latency.
    step(1'b1, 64'h5A, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);
    step(1'b0, 64'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-burst, checked before any clock edge.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 64'h50 + 64'(i), 1'b0, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("rst_mid");
    release_reset();

    // Random traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 64'h0, 1'b1, 1'b0);
    end
    check_val("final_count", 64'(count), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
